// File: rtl/sar_pkg.sv
// sar_pkg: shared FSM state type and default configuration for the SAR controller
package sar_pkg;
  localparam int SAR_N_BITS = 16;
  localparam int SAR_SAMPLE_CYCLES = 2;
  localparam int SAR_SETTLE_CYCLES = 1;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_SETTLE,
    ST_COMPARE,
    ST_WAIT,
    ST_DONE
  } sar_state_t;
endpackage

// File: rtl/sar_timer.sv
// sar_timer: loadable down-counter with zero flag, shared by sample and settle phases
// Ports: clk, rst_n (async active-low), load/load_val (reload), zero (count reached 0)
module sar_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  end
  assign zero = cnt == '0;
endmodule

// File: rtl/sar_logic.sv
// sar_logic: successive-approximation controller driving the SAR capacitor DAC
// Ports: start/cfg_invert_n request a conversion; comp_req/comp_valid/comp_out talk to the
// comparator; sample, dac_state and dac_drive_invert feed the capacitor driver;
// busy/done/result report conversion status and the last completed code.
module sar_logic
  import sar_pkg::*;
#(
  parameter int N_BITS = SAR_N_BITS,
  parameter int SAMPLE_CYCLES = SAR_SAMPLE_CYCLES,
  parameter int SETTLE_CYCLES = SAR_SETTLE_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              cfg_invert_n,
  input  logic              comp_valid,
  input  logic              comp_out,
  output logic              sample,
  output logic              comp_req,
  output logic [N_BITS-1:0] dac_state,
  output logic              dac_drive_invert,
  output logic              busy,
  output logic              done,
  output logic [N_BITS-1:0] result
);
  localparam int KW = $clog2(N_BITS);
  localparam int TMAX = SAMPLE_CYCLES > SETTLE_CYCLES ? SAMPLE_CYCLES : SETTLE_CYCLES;
  localparam int TW = $clog2(TMAX + 1);
  // timer counts down to zero, so a phase of C cycles is loaded with C-1
  localparam logic [TW-1:0] SAMPLE_LD = TW'(SAMPLE_CYCLES - 1);
  localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE_CYCLES > 0 ? SETTLE_CYCLES - 1 : 0);
  // with no settle time the DAC update goes straight to the comparator request
  localparam sar_state_t AFTER_DAC = SETTLE_CYCLES > 0 ? ST_SETTLE : ST_COMPARE;

  sar_state_t state, state_nxt;
  logic [KW-1:0] k;
  logic tmr_load, tmr_zero;
  logic [TW-1:0] tmr_val;
  logic accept, sample_end, bit_done, last;

  assign accept = state == ST_IDLE && start;
  assign sample_end = state == ST_SAMPLE && tmr_zero;
  assign bit_done = state == ST_WAIT && comp_valid;
  assign last = k == '0;

  sar_timer #(.W(TW)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (tmr_load),
    .load_val(tmr_val),
    .zero    (tmr_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tmr_load = 1'b0;
    tmr_val = SETTLE_LD;
    case (state)
      ST_IDLE: begin
        state_nxt = start ? ST_SAMPLE : ST_IDLE;
        tmr_load = start;
        tmr_val = SAMPLE_LD;
      end
      ST_SAMPLE: begin
        state_nxt = tmr_zero ? AFTER_DAC : ST_SAMPLE;
        tmr_load = tmr_zero;
      end
      ST_SETTLE: state_nxt = tmr_zero ? ST_COMPARE : ST_SETTLE;
      ST_COMPARE: state_nxt = ST_WAIT;
      ST_WAIT: begin
        state_nxt = !comp_valid ? ST_WAIT : last ? ST_DONE : AFTER_DAC;
        tmr_load = comp_valid && !last;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dac_state <= '0;
      dac_drive_invert <= 1'b1;
      k <= '0;
      result <= '0;
    end else if (accept) begin
      dac_state <= '0;
      dac_drive_invert <= cfg_invert_n;
    end else if (sample_end) begin
      dac_state[N_BITS-1] <= 1'b1;
      k <= KW'(N_BITS - 1);
    end else if (bit_done) begin
      dac_state[k] <= comp_out;
      if (!last) begin
        dac_state[k - 1'b1] <= 1'b1;
        k <= k - 1'b1;
      end else begin
        result <= {dac_state[N_BITS-1:1], comp_out};
      end
    end
  end

  assign sample = state == ST_SAMPLE;
  assign comp_req = state == ST_COMPARE;
  assign busy = state != ST_IDLE;
  assign done = state == ST_DONE;
endmodule
